// File: rtl/jtframe_nmi_wdog.sv
// jtframe_nmi_wdog
// Vertical-blank NMI generator and watchdog for the Z80 main-CPU glue.
// It sits between the video timing (vb) and the CPU wrapper's nmi_n/rst_n inputs.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   cen          CPU clock enable; everything except the reset-pulse timer is cen-gated
//   vb           vertical blank from video timing
//   nmi_en_we    write strobe for nmi_en (cen-qualified), nmi_en_din is the value
//   wd_en        watchdog enable level
//   kick         watchdog refresh strobe (cen-qualified)
//   wd_clr       clears wd_fired and miss_cnt (cen-qualified)
//   nmi_n        to CPU NMI input (active low)
//   cpu_rst_n    to CPU reset (active low), low for RST_LEN clk after reset or a fire
//   nmi_en       current NMI enable
//   wd_cnt       current watchdog count
//   wd_fired     sticky watchdog-fired flag
//   miss_cnt     saturating count of VB edges that arrived while NMI was still asserted
module jtframe_nmi_wdog #(
  parameter int CNT_W     = 4,
  parameter int WD_LIMIT  = 15,
  parameter int VB_POL    = 1,
  parameter int NMI_MODE  = 0,
  parameter int NMI_PULSE = 8,
  parameter int RST_LEN   = 16,
  parameter int MISS_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              vb,
  input  logic              nmi_en_we,
  input  logic              nmi_en_din,
  input  logic              wd_en,
  input  logic              kick,
  input  logic              wd_clr,
  output logic              nmi_n,
  output logic              cpu_rst_n,
  output logic              nmi_en,
  output logic [CNT_W-1:0]  wd_cnt,
  output logic              wd_fired,
  output logic [MISS_W-1:0] miss_cnt
);

  localparam int PW = $clog2(NMI_PULSE + 1);
  localparam int RW = $clog2(RST_LEN + 1);
  localparam logic VB_ACT = (VB_POL != 0);
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(WD_LIMIT);
  localparam logic [PW-1:0]    PULSE  = PW'(NMI_PULSE);
  localparam logic [RW-1:0]    RLEN   = RW'(RST_LEN);

  logic          vbl;
  logic [PW-1:0] pcnt;
  logic [RW-1:0] rst_cnt;

  logic vb_edge;
  logic edge_ok;
  logic wd_hold;
  logic fire;

  // While the CPU is held in reset (power-on or after a fire) edges are
  // ignored, so nothing can set an NMI or advance the watchdog.
  always_comb begin
    vb_edge = (vb == VB_ACT) && (vbl != VB_ACT);
    edge_ok = cen && vb_edge && cpu_rst_n;
    wd_hold = !wd_en || kick;
    fire    = edge_ok && !wd_hold && (wd_cnt == LIMIT);
  end

  // VB history starts at the inactive level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbl <= ~VB_ACT;
    end else if (cen) begin
      vbl <= vb;
    end
  end

  // Watchdog counter: disable/kick beats the edge, the limit edge fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (cen) begin
      if (wd_hold || !cpu_rst_n || fire) begin
        wd_cnt <= '0;
      end else if (edge_ok) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky fired flag; a fire on the same tick as wd_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_fired <= 1'b0;
    end else if (fire) begin
      wd_fired <= 1'b1;
    end else if (cen && wd_clr) begin
      wd_fired <= 1'b0;
    end
  end

  // CPU reset timer runs on every clk, not on cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt   <= RLEN;
      cpu_rst_n <= 1'b0;
    end else if (fire) begin
      rst_cnt   <= RLEN;
      cpu_rst_n <= 1'b0;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - RW'(1);
      if (rst_cnt == RW'(1)) begin
        cpu_rst_n <= 1'b1;
      end
    end
  end

  // NMI enable and line. Fire and a write of 0 both release the line at once.
  // In pulse mode pcnt counts down the low time; set and countdown are
  // mutually exclusive because countdown only runs while nmi_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_en <= 1'b0;
      nmi_n  <= 1'b1;
      pcnt   <= '0;
    end else if (fire) begin
      nmi_en <= 1'b0;
      nmi_n  <= 1'b1;
      pcnt   <= '0;
    end else if (cen) begin
      if (nmi_en_we && !nmi_en_din) begin
        nmi_en <= 1'b0;
        nmi_n  <= 1'b1;
        pcnt   <= '0;
      end else begin
        if (nmi_en_we) begin
          nmi_en <= 1'b1;
        end
        if (edge_ok && nmi_en && nmi_n) begin
          nmi_n <= 1'b0;
          if (NMI_MODE != 0) begin
            pcnt <= PULSE;
          end
        end else if ((NMI_MODE != 0) && !nmi_n && (pcnt != '0)) begin
          pcnt <= pcnt - PW'(1);
          if (pcnt == PW'(1)) begin
            nmi_n <= 1'b1;
          end
        end
      end
    end
  end

  // Missed-NMI counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (cen && wd_clr) begin
      miss_cnt <= '0;
    end else if (edge_ok && nmi_en && !nmi_n && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + MISS_W'(1);
    end
  end

endmodule

// File: tb/tb_jtframe_nmi_wdog.sv
// Testbench for jtframe_nmi_wdog. Two instances share all inputs:
// dut_a is hold-until-cleared (NMI_MODE=0) with a 2-bit miss counter,
// dut_b is the pulsed mode (NMI_MODE=1, NMI_PULSE=8).
// Stimulus pushes expected values into a queue; a negedge monitor pops
// and compares them against the selected DUT output.
module tb_jtframe_nmi_wdog;

  localparam int W = 16;

  // Selectors for the monitor
  localparam int S_NMI_A  = 0;
  localparam int S_RST_A  = 1;
  localparam int S_EN_A   = 2;
  localparam int S_CNT_A  = 3;
  localparam int S_FIRE_A = 4;
  localparam int S_MISS_A = 5;
  localparam int S_NMI_B  = 6;
  localparam int S_RST_B  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic vb = 1'b0;
  logic nmi_en_we = 1'b0;
  logic nmi_en_din = 1'b0;
  logic wd_en = 1'b0;
  logic kick = 1'b0;
  logic wd_clr = 1'b0;

  logic       nmi_n_a, cpu_rst_n_a, nmi_en_a, wd_fired_a;
  logic [3:0] wd_cnt_a;
  logic [1:0] miss_cnt_a;
  logic       nmi_n_b, cpu_rst_n_b, nmi_en_b, wd_fired_b;
  logic [3:0] wd_cnt_b;
  logic [7:0] miss_cnt_b;

  jtframe_nmi_wdog #(
    .CNT_W(4), .WD_LIMIT(15), .VB_POL(1), .NMI_MODE(0),
    .NMI_PULSE(8), .RST_LEN(16), .MISS_W(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .vb(vb),
    .nmi_en_we(nmi_en_we), .nmi_en_din(nmi_en_din),
    .wd_en(wd_en), .kick(kick), .wd_clr(wd_clr),
    .nmi_n(nmi_n_a), .cpu_rst_n(cpu_rst_n_a), .nmi_en(nmi_en_a),
    .wd_cnt(wd_cnt_a), .wd_fired(wd_fired_a), .miss_cnt(miss_cnt_a)
  );

  jtframe_nmi_wdog #(
    .CNT_W(4), .WD_LIMIT(15), .VB_POL(1), .NMI_MODE(1),
    .NMI_PULSE(8), .RST_LEN(16), .MISS_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .vb(vb),
    .nmi_en_we(nmi_en_we), .nmi_en_din(nmi_en_din),
    .wd_en(wd_en), .kick(kick), .wd_clr(wd_clr),
    .nmi_n(nmi_n_b), .cpu_rst_n(cpu_rst_n_b), .nmi_en(nmi_en_b),
    .wd_cnt(wd_cnt_b), .wd_fired(wd_fired_b), .miss_cnt(miss_cnt_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  function automatic logic [W-1:0] actual(input int s);
    case (s)
      S_NMI_A:  actual = W'(nmi_n_a);
      S_RST_A:  actual = W'(cpu_rst_n_a);
      S_EN_A:   actual = W'(nmi_en_a);
      S_CNT_A:  actual = W'(wd_cnt_a);
      S_FIRE_A: actual = W'(wd_fired_a);
      S_MISS_A: actual = W'(miss_cnt_a);
      S_NMI_B:  actual = W'(nmi_n_b);
      S_RST_B:  actual = W'(cpu_rst_n_b);
      default:  actual = 'x;
    endcase
  endfunction

  function automatic string sel_name(input int s);
    case (s)
      S_NMI_A:  sel_name = "nmi_n_a";
      S_RST_A:  sel_name = "cpu_rst_n_a";
      S_EN_A:   sel_name = "nmi_en_a";
      S_CNT_A:  sel_name = "wd_cnt_a";
      S_FIRE_A: sel_name = "wd_fired_a";
      S_MISS_A: sel_name = "miss_cnt_a";
      S_NMI_B:  sel_name = "nmi_n_b";
      S_RST_B:  sel_name = "cpu_rst_n_b";
      default:  sel_name = "unknown";
    endcase
  endfunction

  int           mon_sel;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      mon_sel = sel_q.pop_front();
      mon_exp = exp_q.pop_front();
      mon_act = actual(mon_sel);
      n_checks++;
      if (mon_act === mon_exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s at %0t: got %0h expected %0h",
                 sel_name(mon_sel), $time, mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input int s, input logic [W-1:0] e);
    sel_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic direct_chk(input string name, input logic [W-1:0] act,
                            input logic [W-1:0] e);
    n_checks++;
    if (act === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One cen tick; strobes are dropped right after it.
  task automatic tick();
    cen = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0;
    nmi_en_we = 1'b0;
    kick = 1'b0;
    wd_clr = 1'b0;
  endtask

  task automatic write_en(input logic v);
    nmi_en_we = 1'b1;
    nmi_en_din = v;
    tick();
  endtask

  task automatic edge_rise();
    vb = 1'b1;
    tick();
  endtask

  task automatic edge_end();
    idle(3);
    vb = 1'b0;
    tick();
    idle(3);
  endtask

  // Safety net: the bench is fixed-length, this only guards against a stall.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Reset values
    chk(S_NMI_A, 1); chk(S_RST_A, 0); chk(S_EN_A, 0);
    chk(S_CNT_A, 0); chk(S_FIRE_A, 0); chk(S_MISS_A, 0);
    chk(S_NMI_B, 1); chk(S_RST_B, 0);
    // Power-on pulse: cpu_rst_n rises on the 16th clk after release
    for (int i = 1; i <= 16; i++) begin
      idle(1);
      chk(S_RST_A, (i == 16) ? 1 : 0);
      chk(S_NMI_A, 1);
    end
    idle(3);
    direct_chk("cpu_rst_n_b", W'(cpu_rst_n_b), 1);

    // NMI enable, first edge sets both lines
    write_en(1'b1);
    chk(S_EN_A, 1);
    idle(3);
    edge_rise();
    chk(S_NMI_A, 0);
    chk(S_NMI_B, 0);
    idle(3);
    vb = 1'b0;
    // Pulse mode: low for exactly 8 cen ticks
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk(S_NMI_B, (k == 8) ? 1 : 0);
      chk(S_NMI_A, 0);
      idle(3);
    end
    direct_chk("nmi_n_b", W'(nmi_n_b), 1);
    // Second edge: hold mode misses, pulse mode re-arms
    edge_rise();
    chk(S_NMI_A, 0);
    chk(S_MISS_A, 1);
    chk(S_NMI_B, 0);
    edge_end();
    // Writing 0 releases both lines on that tick
    write_en(1'b0);
    chk(S_NMI_A, 1);
    chk(S_EN_A, 0);
    chk(S_NMI_B, 1);
    idle(3);

    // Miss counter saturation on a 2-bit counter
    write_en(1'b1);
    idle(3);
    edge_rise();
    chk(S_NMI_A, 0);
    chk(S_MISS_A, 1);
    edge_end();
    for (int k = 1; k <= 5; k++) begin
      edge_rise();
      chk(S_MISS_A, (k + 1 > 3) ? 3 : k + 1);
      edge_end();
    end
    wd_clr = 1'b1;
    tick();
    chk(S_MISS_A, 0);
    chk(S_FIRE_A, 0);
    idle(3);

    // Watchdog climbs 1..15
    wd_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      edge_rise();
      chk(S_CNT_A, k);
      edge_end();
    end
    // 16th edge fires
    edge_rise();
    chk(S_FIRE_A, 1); chk(S_CNT_A, 0); chk(S_EN_A, 0);
    chk(S_NMI_A, 1); chk(S_RST_A, 0);
    direct_chk("wd_fired_b", W'(wd_fired_b), 1);
    direct_chk("cpu_rst_n_b", W'(cpu_rst_n_b), 0);
    // Reset pulse of 16 clk; an edge mid-pulse (with NMI re-enabled) is ignored
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) begin
        vb = 1'b0;
        nmi_en_we = 1'b1;
        nmi_en_din = 1'b1;
        tick();
      end else if (i == 8) begin
        vb = 1'b1;
        tick();
        chk(S_CNT_A, 0);
        chk(S_NMI_A, 1);
        chk(S_FIRE_A, 1);
      end else if (i == 12) begin
        vb = 1'b0;
        tick();
      end else begin
        idle(1);
      end
      chk(S_RST_A, (i == 16) ? 1 : 0);
    end
    idle(3);
    wd_clr = 1'b1;
    tick();
    chk(S_FIRE_A, 0);
    chk(S_MISS_A, 0);
    idle(3);

    // Kick beats an edge at the limit
    for (int k = 1; k <= 15; k++) begin
      edge_rise();
      edge_end();
    end
    chk(S_CNT_A, 15);
    vb = 1'b1;
    kick = 1'b1;
    tick();
    chk(S_CNT_A, 0);
    chk(S_FIRE_A, 0);
    chk(S_RST_A, 1);
    direct_chk("wd_cnt_b", W'(wd_cnt_b), 0);
    edge_end();

    // Watchdog disabled: 40 edges leave the count at 0
    wd_en = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      edge_rise();
      if (k % 10 == 0) chk(S_CNT_A, 0);
      edge_end();
    end
    chk(S_FIRE_A, 0);
    chk(S_MISS_A, 3);

    // Asynchronous reset in the middle of an NMI pulse
    write_en(1'b0);
    idle(3);
    write_en(1'b1);
    idle(3);
    edge_rise();
    chk(S_NMI_B, 0);
    chk(S_NMI_A, 0);
    idle(1);
    rst_n = 1'b0;
    chk(S_NMI_A, 1); chk(S_RST_A, 0); chk(S_EN_A, 0);
    chk(S_CNT_A, 0); chk(S_FIRE_A, 0); chk(S_MISS_A, 0);
    chk(S_NMI_B, 1); chk(S_RST_B, 0);
    idle(2);
    rst_n = 1'b1;
    vb = 1'b0;
    idle(2);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass == n_checks && n_checks > 0) begin
      $display("PASS");
    end else begin
      $display("FAIL");
    end
    $finish;
  end

endmodule

// File: doc/jtframe_nmi_wdog.md
Name: jtframe_nmi_wdog

Overview:
- Parametrised vertical-blank NMI generator and watchdog for the Z80 main-CPU glue in jtpopeye and later cores.
- Generalises the fixed Popeye scheme (hold-until-cleared NMI, 4-bit VB-count watchdog) with configurable counter width, limit, VB polarity and NMI mode.
- Adds missed-NMI counting, a timed CPU reset pulse and a sticky watchdog-fired flag.
- Sits between the video timing (VB) and the CPU wrapper's nmi_n and rst_n inputs.

Parameters:
- CNT_W, 4: watchdog counter width.
- WD_LIMIT, 15: counter value at which the next VB edge fires the watchdog; must be < 2^CNT_W.
- VB_POL, 1: 1 = NMI/count on VB rising edge, 0 = on falling edge.
- NMI_MODE, 0: 0 = nmi_n held low until nmi_en cleared; 1 = nmi_n low for NMI_PULSE cen ticks, then auto-release.
- NMI_PULSE, 8: pulse length in cen ticks (NMI_MODE=1 only), ≥1.
- RST_LEN, 16: cpu_rst_n low time in clk cycles, ≥2.
- MISS_W, 8: missed-NMI counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- cen  in  1  CPU clock enable; all sampling except the reset-pulse timer is cen-gated
- vb  in  1  vertical blank from video timing
- nmi_en_we  in  1  write strobe for nmi_en (cen-qualified)
- nmi_en_din  in  1  new nmi_en value
- wd_en  in  1  watchdog enable level
- kick  in  1  watchdog refresh strobe (cen-qualified)
- wd_clr  in  1  clears wd_fired and miss_cnt (cen-qualified)
- nmi_n  out  1  to CPU NMI input
- cpu_rst_n  out  1  to CPU reset
- nmi_en  out  1  current NMI enable
- wd_cnt  out  CNT_W  current watchdog count
- wd_fired  out  1  sticky: watchdog has fired
- miss_cnt  out  MISS_W  VB edges that arrived while NMI still asserted

Behaviour:
Reset and timing
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: nmi_n=1, cpu_rst_n=0, nmi_en=0, wd_cnt=0, wd_fired=0, miss_cnt=0, pulse counter=0, VB history = inactive level (no spurious edge after reset).
- Edge detect: vbl register updated on cen. Edge = (vb==VB_POL) && (vbl!=VB_POL), evaluated on cen ticks only.

NMI enable and assertion
- nmi_en_we on a cen tick loads nmi_en. Writing 0 forces nmi_n=1 on that same tick and clears the pulse counter. This takes priority over an edge on the same tick.
- NMI set: edge && nmi_en && nmi_n==1 → nmi_n=0. In mode 1 this also loads the pulse counter with NMI_PULSE.
- Mode 1 release: pulse counter decrements each cen tick; at the tick it reaches 0, nmi_n returns to 1. Low time is exactly NMI_PULSE cen ticks.
- Missed NMI: edge && nmi_en && nmi_n==0 → miss_cnt+1, saturating at all-ones. nmi_n is unchanged.
- An edge with nmi_en=0 does nothing.

Watchdog
- Counter evaluated on cen ticks, in priority order:
  1. !wd_en or kick → wd_cnt=0 (kick beats a simultaneous edge).
  2. Edge with wd_cnt==WD_LIMIT → fire.
  3. Edge → wd_cnt+1.
- Fire:
  - wd_cnt=0, wd_fired=1, nmi_en=0, nmi_n=1.
  - Start the reset timer: cpu_rst_n=0 for RST_LEN clk cycles (not cen-gated), then 1.
  - During the pulse the counter is held at 0 and edges are ignored for both NMI and watchdog.
- wd_clr clears wd_fired and miss_cnt. A fire on the same tick wins for wd_fired.

Power-on reset pulse
- After rst_n rises, cpu_rst_n stays 0 for RST_LEN clk cycles, then goes 1.
- rst_n asserted mid-pulse or mid-NMI aborts everything to reset values immediately.

Outputs
- All outputs are registered.

Test Plan:
- Power-on: release rst_n, RST_LEN=16 → cpu_rst_n rises exactly 16 clk after release; nmi_n=1 throughout; wd_cnt=0.
- NMI_MODE=0, nmi_en=1, VB rising edge → nmi_n=0 on that cen tick. A second VB edge → miss_cnt=1, nmi_n stays 0. Write nmi_en=0 → nmi_n=1 on that tick.
- NMI_MODE=1, NMI_PULSE=8, nmi_en=1, VB edge → nmi_n low for exactly 8 cen ticks. With cen every 4 clk that is 32 clk, then high.
- Watchdog, WD_LIMIT=15, wd_en=1, no kicks:
  - wd_cnt climbs 1..15 over 15 edges.
  - 16th edge → wd_fired=1, cpu_rst_n low 16 clk, nmi_en=0, wd_cnt=0.
  - Edge during the pulse → no change.
- Kick and VB edge on the same cen tick with wd_cnt=15 → wd_cnt=0, no fire. wd_en=0 for 40 edges → wd_cnt stays 0.
- miss_cnt saturation (MISS_W=2): 5 missed edges → miss_cnt=3. wd_clr → miss_cnt=0, wd_fired=0. Assert rst_n during an NMI pulse → all outputs at reset values immediately.
